inverter_prober: RTL and testbench

Digital stimulus-and-check engine for the single-transistor-pair inverter exposed on the analog pins. It drives a programmable 8-bit pattern, one bit at a time, onto the inverter input pad. After a settle window it samples the inverter output pad and checks each sample against the expected inverted value. It sits in the digital domain of the tile, on the driving/sensing end of the inverter's In/Out pad pair, and reports captured data, a mismatch count and pass/fail to the dedicated outputs.

---
 rtl/inverter_prober_pkg.sv | 8 +
 rtl/inverter_prober_if.sv | 17 +
 rtl/inverter_prober_sync2.sv | 19 +
 rtl/inverter_prober.sv | 95 +++++++++
 tb/tb_inverter_prober.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/inverter_prober_pkg.sv
// Shared types and widths for the inverter stimulus/check engine.
package inverter_prober_pkg;
  localparam int PATTERN_W = 8;
  localparam int ERR_W     = 4;
  localparam int BIT_W     = $clog2(PATTERN_W);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
endpackage

// File: rtl/inverter_prober_if.sv
// Control/result bundle between a host and the inverter prober.
interface inverter_prober_if;
  import inverter_prober_pkg::*;

  logic                 start;
  logic [PATTERN_W-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_count;
  logic [PATTERN_W-1:0] captured;

  modport master (output start, pattern,
                  input  busy, done, pass, err_count, captured);
  modport slave  (input  start, pattern,
                  output busy, done, pass, err_count, captured);
endinterface

// File: rtl/inverter_prober_sync2.sv
// Two-flop synchronizer for the asynchronous sense pad.
module inverter_prober_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/inverter_prober.sv
// Drives an 8-bit pattern onto the inverter pad bit by bit and checks each
// settled response against the inverted drive value.
module inverter_prober
  import inverter_prober_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  inverter_prober_if.slave    bus,
  input  logic                sense_i,
  output logic                drive_o
);
  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [PATTERN_W-1:0] pattern_q;
  logic                 sense_sync;
  logic                 busy_q, done_q, pass_q;
  logic [ERR_W-1:0]     err_q;
  logic [PATTERN_W-1:0] cap_q;

  inverter_prober_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sense_i),
    .q   (sense_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      pattern_q <= '0;
      drive_o   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      cap_q     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          pattern_q <= bus.pattern;
          bit_idx   <= '0;
          cnt       <= '0;
          drive_o   <= bus.pattern[0];
          err_q     <= '0;
          cap_q     <= '0;
          pass_q    <= 1'b0;
          busy_q    <= 1'b1;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          cap_q[bit_idx] <= sense_sync;
          if (sense_sync != ~pattern_q[bit_idx])
            err_q <= err_q + ERR_W'(1);
          // busy/done are registered decodes of the next state
          if (bit_idx == BIT_W'(PATTERN_W - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            bit_idx <= bit_idx + BIT_W'(1);
            drive_o <= pattern_q[bit_idx + BIT_W'(1)];
            state   <= SETTLE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          pass_q  <= (err_q == '0);
          drive_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.captured  = cap_q;
endmodule

// File: tb/tb_inverter_prober.sv
// Self-checking bench: pad model on the inverter pins, directed table plus
// randomized runs against a cycle-timeline reference model.
module tb_inverter_prober;
  import inverter_prober_pkg::*;

  localparam int S      = 4;
  localparam int DONE_C = 8 * (S + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  logic sense_i;
  logic drive_o;

  inverter_prober_if bus ();

  inverter_prober #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sense_i (sense_i),
    .drive_o (drive_o)
  );

  always #5 clk = ~clk;

  // Pad model: mode 0 inverter, 1 buffer, 2 stuck-0, 3 stuck-1; pad_dly cycles.
  int         pad_mode = 0;
  int         pad_dly  = 1;
  logic [7:0] dline    = '0;
  always @(posedge clk) dline <= {dline[6:0], drive_o};
  always_comb begin
    sense_i = 1'b0;
    case (pad_mode)
      0:       sense_i = ~dline[pad_dly-1];
      1:       sense_i = dline[pad_dly-1];
      2:       sense_i = 1'b0;
      default: sense_i = 1'b1;
    endcase
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bit k is sampled in cycle (k+1)(S+1) and sees the pad drive
  // from d+2 cycles earlier; drive in cycle c>=1 is pattern bit (c-1)/(S+1).
  function automatic void model(input logic [7:0] p, input int mode, input int d,
                                output logic [7:0] cap, output int err);
    int   t;
    logic drv, sn;
    err = 0;
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      t   = (k + 1) * (S + 1) - (d + 2);
      drv = (t < 1) ? 1'b0 : p[(t - 1) / (S + 1)];
      case (mode)
        0:       sn = ~drv;
        1:       sn = drv;
        2:       sn = 1'b0;
        default: sn = 1'b1;
      endcase
      cap[k] = sn;
      if (sn != ~p[k]) err++;
    end
  endfunction

  task automatic run(input logic [7:0] p, input int mode, input int d,
                     input int ign_a, input int ign_b,
                     input logic [7:0] exp_cap, input int exp_err, input string tag);
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = -1;
    pad_mode = mode;
    pad_dly  = d;
    repeat (10) @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = p;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.pattern = 8'($urandom);
    check({tag, " busy@1"}, 32'(bus.busy), 32'd1);
    check({tag, " drive@1"}, 32'(drive_o), 32'(p[0]));
    for (int n = 1; n <= DONE_C + 12; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      bus.start = (n == ign_a) || (n == ign_b);
    end
    bus.start = 1'b0;
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'(DONE_C));
    check({tag, " captured"}, 32'(bus.captured), 32'(exp_cap));
    check({tag, " err_count"}, 32'(bus.err_count), 32'(exp_err));
    check({tag, " pass"}, 32'(bus.pass), 32'(exp_err == 0));
    check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, " drive_end"}, 32'(drive_o), 32'd0);
  endtask

  typedef struct {
    logic [7:0] p;
    int         mode;
    int         d;
    int         ign_a;
    int         ign_b;
    logic [7:0] cap;
    int         err;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [7:0] rp, mcap;
    int         rmode, rd, merr;

    tbl[0] = '{8'hA5, 0, 1, 0,  0,  8'h5A, 0};
    tbl[1] = '{8'hA5, 2, 1, 0,  0,  8'h00, 4};
    tbl[2] = '{8'h3C, 1, 1, 0,  0,  8'h3C, 8};
    tbl[3] = '{8'h55, 0, 5, 0,  0,  8'h55, 8};
    tbl[4] = '{8'hA5, 0, 1, 10, 41, 8'h5A, 0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst drive_o", 32'(drive_o), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst pass", 32'(bus.pass), 32'd0);
    check("rst err_count", 32'(bus.err_count), 32'd0);
    check("rst captured", 32'(bus.captured), 32'd0);

    for (int i = 0; i < 5; i++)
      run(tbl[i].p, tbl[i].mode, tbl[i].d, tbl[i].ign_a, tbl[i].ign_b,
          tbl[i].cap, tbl[i].err, $sformatf("tbl%0d", i));

    // pass/captured hold while idle
    repeat (5) @(negedge clk);
    check("idle hold pass", 32'(bus.pass), 32'd1);
    check("idle hold captured", 32'(bus.captured), 32'h5A);

    // Mid-sequence reset: stuck-1 pad, pattern 0x09 leaves nonzero state at cycle 20
    pad_mode = 3;
    pad_dly  = 1;
    repeat (10) @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = 8'h09;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre-rst busy", 32'(bus.busy), 32'd1);
    check("pre-rst drive", 32'(drive_o), 32'd1);
    check("pre-rst captured", 32'(bus.captured), 32'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst drive_o", 32'(drive_o), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst err_count", 32'(bus.err_count), 32'd0);
    check("midrst captured", 32'(bus.captured), 32'd0);
    check("midrst pass", 32'(bus.pass), 32'd0);
    run(8'hFF, 0, 1, 0, 0, 8'h00, 0, "post-rst");

    for (int i = 0; i < 12; i++) begin
      rp    = 8'($urandom);
      rmode = $urandom_range(0, 3);
      rd    = $urandom_range(1, 6);
      model(rp, rmode, rd, mcap, merr);
      run(rp, rmode, rd, $urandom_range(2, DONE_C), 0, mcap, merr,
          $sformatf("rnd%0d p=%02h m%0d d%0d", i, rp, rmode, rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
